// File: rtl/servo_capture_mc.sv
// ============================================================================
// Module   : servo_capture_mc
// Brief    : Multi-channel RC servo pulse decoder with window check, scaling,
//            saturation, sticky pulse errors and signal-loss detection.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module servo_capture_mc #(
    parameter int NCH         = 4,
    parameter int CNT_W       = 17,
    parameter int SHIFT       = 5,
    parameter int CMD_W       = 10,
    parameter int SYNC_STAGES = 3,
    parameter int MIN_W       = 24000,
    parameter int MAX_W       = 72000,
    parameter int TIMEOUT     = 1600000
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NCH-1:0]       servo_i,
    input  logic [NCH*CMD_W-1:0] offset_i,
    input  logic [NCH-1:0]       clr_err_i,
    output logic [NCH*CMD_W-1:0] command_o,
    output logic [NCH-1:0]       cmd_valid_o,
    output logic [NCH-1:0]       pulse_err_o,
    output logic [NCH-1:0]       lost_o
);

    localparam int              c_TMO_W   = $clog2(TIMEOUT + 1);
    localparam logic [c_TMO_W-1:0] c_TMO  = c_TMO_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] c_MIN    = CNT_W'(MIN_W);
    localparam logic [CNT_W-1:0] c_MAX    = CNT_W'(MAX_W);
    localparam logic [CNT_W:0]   c_CMD_MAX = {{(CNT_W + 1 - CMD_W){1'b0}}, {CMD_W{1'b1}}};

    // Tracks which synchroniser stages hold real samples since reset, so the
    // cleared flops are not mistaken for a low level when arming.
    logic [SYNC_STAGES-1:0] fill_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fill_q <= '0;
        end else begin
            fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    generate
        for (genvar i = 0; i < NCH; i++) begin : g_ch
            logic [SYNC_STAGES-1:0] sync_q;
            logic                   p_q;
            logic                   armed_q, armed_d;
            logic [CNT_W-1:0]       cnt_q, cnt_d;
            logic [c_TMO_W-1:0]     tmo_q, tmo_d;
            logic [CMD_W-1:0]       cmd_q, cmd_d;
            logic                   vld_q, vld_d;
            logic                   err_q, err_d;
            logic                   lost_q, lost_d;
            logic                   s, rise, fall, bad;
            logic [CNT_W:0]         x;

            always_comb begin
                s       = sync_q[SYNC_STAGES-1];
                rise    = armed_q & s & ~p_q;
                fall    = armed_q & ~s & p_q;
                armed_d = armed_q | (fill_q[SYNC_STAGES-1] & ~s);

                cnt_d = cnt_q;
                if (rise) begin
                    cnt_d = CNT_W'(1);
                end else if (s && p_q && (cnt_q != c_CNT_MAX)) begin
                    cnt_d = cnt_q + 1'b1;
                end

                tmo_d = tmo_q;
                if (rise) begin
                    tmo_d = '0;
                end else if (tmo_q != c_TMO) begin
                    tmo_d = tmo_q + 1'b1;
                end

                bad = (cnt_q < c_MIN) || (cnt_q > c_MAX) || (cnt_q == c_CNT_MAX);
                x   = {1'b0, cnt_q >> SHIFT} - (CNT_W + 1)'(offset_i[i*CMD_W +: CMD_W]);

                cmd_d  = cmd_q;
                vld_d  = 1'b0;
                err_d  = err_q & ~clr_err_i[i];
                lost_d = lost_q | (tmo_d == c_TMO);
                if (fall) begin
                    if (bad) begin
                        err_d = 1'b1;
                    end else begin
                        vld_d  = 1'b1;
                        lost_d = 1'b0;
                        if (x[CNT_W]) begin
                            cmd_d = '0;
                        end else if (x > c_CMD_MAX) begin
                            cmd_d = '1;
                        end else begin
                            cmd_d = x[CMD_W-1:0];
                        end
                    end
                end
            end

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    sync_q  <= '0;
                    p_q     <= 1'b0;
                    armed_q <= 1'b0;
                    cnt_q   <= '0;
                    tmo_q   <= '0;
                    cmd_q   <= '0;
                    vld_q   <= 1'b0;
                    err_q   <= 1'b0;
                    lost_q  <= 1'b1;
                end else begin
                    sync_q  <= {sync_q[SYNC_STAGES-2:0], servo_i[i]};
                    p_q     <= s;
                    armed_q <= armed_d;
                    cnt_q   <= cnt_d;
                    tmo_q   <= tmo_d;
                    cmd_q   <= cmd_d;
                    vld_q   <= vld_d;
                    err_q   <= err_d;
                    lost_q  <= lost_d;
                end
            end

            assign command_o[i*CMD_W +: CMD_W] = cmd_q;
            assign cmd_valid_o[i]              = vld_q;
            assign pulse_err_o[i]              = err_q;
            assign lost_o[i]                   = lost_q;
        end
    endgenerate

endmodule

`default_nettype wire
